pc_fetch_ctrl: RTL

- Sequences the program counter for the multi-cycle/pipelined core variant.
- Issues instruction-memory requests over a valid/ready port and holds each fetched instruction until decode accepts it.
- Applies branch/jump redirects, trap entry and mret return with fixed priority.
- Sits between the PC state and the decode stage; it replaces the free-running next-PC update.

---
 rtl/pc_ctrl_pkg.sv | 27 ++
 rtl/pc_next_mux.sv | 77 +++++++
 rtl/pc_fetch_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the fetch controller: FSM states,
// instruction length, default vectors and next-pc source encoding.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_DROP
  } fetch_state_e;

  localparam int ILEN_BYTES = 4;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

  // Next-pc source, listed lowest to highest priority.
  typedef enum logic [2:0] {
    EV_NONE,
    EV_ADVANCE,
    EV_REDIRECT,
    EV_MISALIGN,
    EV_MRET,
    EV_TRAP
  } pc_event_e;

endpackage

// File: rtl/pc_next_mux.sv
// Priority select of the next pc and the exception-pc write.
// trap > mret > redirect (misaligned redirect becomes a trap) > advance.
module pc_next_mux
  import pc_ctrl_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(DEF_TRAP_VEC)
) (
  input  logic            trap,
  input  logic            mret,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            advance,
  input  logic            in_hold,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] epc,
  input  logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] pc_nxt,
  output logic            pc_we,
  output logic [XLEN-1:0] epc_nxt,
  output logic            epc_we,
  output logic            misalign,
  output logic            event_taken
);

  pc_event_e sel;

  // Resolve which source owns the pc this cycle.
  always_comb begin
    sel = EV_NONE;
    if (trap)                          sel = EV_TRAP;
    else if (mret)                     sel = EV_MRET;
    else if (redirect && (redirect_pc[1:0] != 2'b00)) sel = EV_MISALIGN;
    else if (redirect)                 sel = EV_REDIRECT;
    else if (advance)                  sel = EV_ADVANCE;
  end

  // Drive the pc / epc update for the selected source.
  always_comb begin
    pc_nxt  = pc;
    pc_we   = 1'b0;
    epc_nxt = epc;
    epc_we  = 1'b0;
    case (sel)
      EV_TRAP: begin
        pc_nxt  = TRAP_VEC;
        pc_we   = 1'b1;
        // A held instruction is the one that faulted; otherwise the fetch pc.
        epc_nxt = in_hold ? if_pc : pc;
        epc_we  = 1'b1;
      end
      EV_MRET: begin
        pc_nxt = epc;
        pc_we  = 1'b1;
      end
      EV_MISALIGN: begin
        pc_nxt  = TRAP_VEC;
        pc_we   = 1'b1;
        epc_nxt = pc;
        epc_we  = 1'b1;
      end
      EV_REDIRECT: begin
        pc_nxt = redirect_pc;
        pc_we  = 1'b1;
      end
      EV_ADVANCE: begin
        pc_nxt = pc + XLEN'(ILEN_BYTES);
        pc_we  = 1'b1;
      end
      default: ;
    endcase
  end

  assign misalign    = (sel == EV_MISALIGN);
  assign event_taken = trap | mret | redirect;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter sequencer: one outstanding imem request, holds the
// fetched word for decode, applies trap/mret/redirect with stale-response drop.
module pc_fetch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEF_TRAP_VEC)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  input  logic            if_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_req,
  input  logic            mret,
  output logic [XLEN-1:0] epc_o,
  output logic            misalign_err
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] epc_nxt;
  logic            pc_we;
  logic            epc_we;
  logic            mis_taken;
  logic            ev;
  logic            req_acc;

  assign imem_req_addr = pc;
  // imem_req_valid is low for the first cycle after reset, so gate acceptance on it.
  assign req_acc       = imem_req_valid & imem_req_ready;

  pc_next_mux #(
    .XLEN     (XLEN),
    .TRAP_VEC (TRAP_VEC)
  ) u_next_mux (
    .trap        (trap_req),
    .mret        (mret),
    .redirect    (redirect_valid),
    .redirect_pc (redirect_pc),
    .advance     ((state == ST_HOLD) && if_ready),
    .in_hold     (state == ST_HOLD),
    .pc          (pc),
    .epc         (epc_o),
    .if_pc       (if_pc),
    .pc_nxt      (pc_nxt),
    .pc_we       (pc_we),
    .epc_nxt     (epc_nxt),
    .epc_we      (epc_we),
    .misalign    (mis_taken),
    .event_taken (ev)
  );

  // Fetch FSM with registered request/decode valids and pc/epc state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_REQ;
      pc             <= RESET_VEC;
      epc_o          <= '0;
      imem_req_valid <= 1'b0;
      if_valid       <= 1'b0;
      if_pc          <= '0;
      if_instr       <= '0;
      misalign_err   <= 1'b0;
    end else begin
      misalign_err <= mis_taken;
      if (pc_we)  pc    <= pc_nxt;
      if (epc_we) epc_o <= epc_nxt;
      case (state)
        ST_REQ: begin
          if (req_acc) begin
            // An event alongside acceptance makes the accepted fetch stale.
            state          <= ev ? ST_DROP : ST_WAIT;
            imem_req_valid <= 1'b0;
          end else begin
            imem_req_valid <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            if (ev) begin
              state          <= ST_REQ;
              imem_req_valid <= 1'b1;
            end else begin
              state    <= ST_HOLD;
              if_valid <= 1'b1;
              if_instr <= imem_rsp_data;
              if_pc    <= pc;
            end
          end else if (ev) begin
            state <= ST_DROP;
          end
        end
        ST_HOLD: begin
          if (ev || if_ready) begin
            state          <= ST_REQ;
            if_valid       <= 1'b0;
            imem_req_valid <= 1'b1;
          end
        end
        ST_DROP: begin
          if (imem_rsp_valid) begin
            state          <= ST_REQ;
            imem_req_valid <= 1'b1;
          end
        end
        default: state <= ST_REQ;
      endcase
    end
  end

endmodule
